// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the pipeline memory-access stage.
// Holds the FSM state encoding, default widths and the MEM/WB bubble value.
package mem_access_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int RA_W_DEF   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Register-file write enables presented at the MEM/WB boundary.
    typedef struct packed {
        logic reg_write;
        logic r0_write;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '{reg_write: 1'b0, r0_write: 1'b0};

    // Controls captured when a memory access is accepted.
    typedef struct packed {
        wb_ctrl_t wb;
        logic     mem_source;
        logic     is_load;
    } hold_ctrl_t;

endpackage

// File: rtl/mem_access_stage_timeout.sv
// Saturating wait counter for an outstanding memory access.
// Flags the terminal count so the stage can abort a non-responding memory.
module mem_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int                CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over req/ack, stalls upstream
// while busy, and registers writeback values for the MEM/WB boundary.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RA_W    = RA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic              r0Write,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memSource,
    input  logic [RA_W-1:0]   RA1,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [DATA_W-1:0] R0D,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              regWrite_o,
    output logic              r0Write_o,
    output logic [RA_W-1:0]   RA1_o,
    output logic [DATA_W-1:0] WBData_o,
    output logic [DATA_W-1:0] R0D_o,
    output logic              err_o
);

    state_e            r_state;
    state_e            w_next_state;
    logic              w_memop;
    logic              w_stall;
    logic              w_accept;
    logic              w_done;
    logic              w_abort;
    logic              w_terminal;
    logic              w_load_sel;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    hold_ctrl_t        r_hold;
    logic [RA_W-1:0]   r_hold_ra1;
    logic [DATA_W-1:0] r_hold_r0d;

    wb_ctrl_t          r_wb_ctrl;
    logic [RA_W-1:0]   r_ra1_o;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] r_r0d_o;
    logic              r_err;

    assign w_memop = memRead | memWrite;

    mem_timeout_counter #(
        .TIMEOUT    (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state == ST_IDLE),
        .i_enable   ((r_state == ST_BUSY) && !mem_ack),
        .o_terminal (w_terminal)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    w_stall      = 1'b1;
                    w_accept     = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completion in the terminal cycle takes priority over the abort.
                if (mem_ack) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_terminal) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_stall      = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hold      <= '0;
            r_hold_ra1  <= '0;
            r_hold_r0d  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_mem_req            <= 1'b1;
                r_mem_we             <= memWrite;
                r_mem_addr           <= ALUResult;
                r_mem_wdata          <= DataIn;
                r_hold.wb.reg_write  <= regWrite;
                r_hold.wb.r0_write   <= r0Write;
                r_hold.mem_source    <= memSource;
                r_hold.is_load       <= memRead & ~memWrite;
                r_hold_ra1           <= RA1;
                r_hold_r0d           <= R0D;
            end else if (w_done || w_abort) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    assign w_load_sel = r_hold.mem_source & r_hold.is_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_ctrl <= WB_CTRL_BUBBLE;
            r_ra1_o   <= '0;
            r_wb_data <= '0;
            r_r0d_o   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_abort) begin
                r_err <= 1'b1;
            end
            if (w_done) begin
                r_wb_ctrl <= r_hold.wb;
                r_ra1_o   <= r_hold_ra1;
                r_wb_data <= w_load_sel ? mem_rdata : r_mem_addr;
                r_r0d_o   <= r_hold_r0d;
            end else if (w_accept || w_abort) begin
                r_wb_ctrl <= WB_CTRL_BUBBLE;
                r_ra1_o   <= '0;
                r_wb_data <= '0;
                r_r0d_o   <= '0;
            end else if (r_state == ST_IDLE) begin
                r_wb_ctrl.reg_write <= regWrite;
                r_wb_ctrl.r0_write  <= r0Write;
                r_ra1_o             <= RA1;
                r_wb_data           <= ALUResult;
                r_r0d_o             <= R0D;
            end
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign stall      = w_stall;
    assign regWrite_o = r_wb_ctrl.reg_write;
    assign r0Write_o  = r_wb_ctrl.r0_write;
    assign RA1_o      = r_ra1_o;
    assign WBData_o   = r_wb_data;
    assign R0D_o      = r_r0d_o;
    assign err_o      = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected writebacks and
// requests; a monitor pops and compares whenever the DUT presents them.
module tb_mem_access_stage;

    localparam int DATA_W  = 16;
    localparam int RA_W    = 4;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              regWrite, r0Write, memRead, memWrite, memSource;
    logic [RA_W-1:0]   RA1;
    logic [DATA_W-1:0] ALUResult, DataIn, R0D;
    logic              mem_req, mem_we, mem_ack;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic              stall, regWrite_o, r0Write_o, err_o;
    logic [RA_W-1:0]   RA1_o;
    logic [DATA_W-1:0] WBData_o, R0D_o;

    typedef struct {
        logic rw, r0w, mr, mw, ms;
        logic [3:0] ra;
        logic [15:0] alu, din, r0d;
    } ex_t;
    typedef struct {
        logic rw, r0w;
        logic [3:0] ra;
        logic [15:0] data, r0d;
    } wb_t;
    typedef struct {
        logic we;
        logic [15:0] addr, wdata;
        int width;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mem_access_stage #(
        .DATA_W(DATA_W), .RA_W(RA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .regWrite(regWrite), .r0Write(r0Write), .memRead(memRead), .memWrite(memWrite),
        .memSource(memSource), .RA1(RA1), .ALUResult(ALUResult), .DataIn(DataIn), .R0D(R0D),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .regWrite_o(regWrite_o), .r0Write_o(r0Write_o), .RA1_o(RA1_o),
        .WBData_o(WBData_o), .R0D_o(R0D_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ex_t mk(input logic rw, input logic r0w, input logic mr, input logic mw,
                               input logic ms, input logic [3:0] ra, input logic [15:0] alu,
                               input logic [15:0] din, input logic [15:0] r0d);
        ex_t e;
        e.rw = rw; e.r0w = r0w; e.mr = mr; e.mw = mw; e.ms = ms;
        e.ra = ra; e.alu = alu; e.din = din; e.r0d = r0d;
        return e;
    endfunction

    task automatic drive(input ex_t op);
        regWrite = op.rw; r0Write = op.r0w; memRead = op.mr; memWrite = op.mw;
        memSource = op.ms; RA1 = op.ra; ALUResult = op.alu; DataIn = op.din; R0D = op.r0d;
    endtask

    task automatic push_wb(input logic rw, input logic r0w, input logic [3:0] ra,
                           input logic [15:0] data, input logic [15:0] r0d);
        wb_t e;
        e.rw = rw; e.r0w = r0w; e.ra = ra; e.data = data; e.r0d = r0d;
        wb_q.push_back(e);
    endtask

    task automatic push_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input int width);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.width = width;
        req_q.push_back(r);
    endtask

    // Called at a falling edge; plays the EX/MEM register (holding while stalled)
    // and the memory, acking ack_delay cycles after the request rises (-1 = never).
    task automatic issue(input ex_t op, input int ack_delay, input logic [15:0] rdata,
                         input int exp_stall, input string name);
        int req_cyc = 0;
        int n_stall = 0;
        bit done    = 1'b0;
        drive(op);
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (mem_req) begin
                mem_ack   = (req_cyc == ack_delay);
                mem_rdata = rdata;
                req_cyc++;
            end else begin
                mem_ack = 1'b0;
            end
            #1;
            if (stall) n_stall++;
            else       done = 1'b1;
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(mk(0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 16'h0));
        check({name, "_completed"}, 64'(done), 64'd1);
        check({name, "_stall_cycles"}, 64'(n_stall), 64'(exp_stall));
    endtask

    // Monitor: pops the scoreboard on each writeback and each request pulse.
    initial begin
        wb_t  e;
        req_t cur;
        bit   have     = 1'b0;
        bit   prev_req = 1'b0;
        int   req_w    = 0;
        forever begin
            @(posedge clk);
            #2;
            if (regWrite_o || r0Write_o) begin
                check("wb_pending", 64'(wb_q.size() > 0), 64'd1);
                if (wb_q.size() > 0) begin
                    e = wb_q.pop_front();
                    check("wb_regWrite", 64'(regWrite_o), 64'(e.rw));
                    check("wb_r0Write", 64'(r0Write_o), 64'(e.r0w));
                    check("wb_RA1", 64'(RA1_o), 64'(e.ra));
                    check("wb_WBData", 64'(WBData_o), 64'(e.data));
                    check("wb_R0D", 64'(R0D_o), 64'(e.r0d));
                end
            end
            if (mem_req && !prev_req) begin
                check("req_pending", 64'(req_q.size() > 0), 64'd1);
                req_w = 1;
                have  = (req_q.size() > 0);
                if (have) begin
                    cur = req_q.pop_front();
                    check("req_we", 64'(mem_we), 64'(cur.we));
                    check("req_addr", 64'(mem_addr), 64'(cur.addr));
                    check("req_wdata", 64'(mem_wdata), 64'(cur.wdata));
                end
            end else if (mem_req) begin
                req_w++;
                if (have) check("req_addr_stable", 64'({mem_we, mem_addr}), 64'({cur.we, cur.addr}));
            end else if (prev_req && have) begin
                check("req_width", 64'(req_w), 64'(cur.width));
                have = 1'b0;
            end
            prev_req = mem_req;
        end
    end

    initial begin
        ex_t nop;
        nop       = mk(0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 16'h0);
        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(nop);
        repeat (2) @(negedge clk);
        check("rst_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
        check("rst_wb", 64'({regWrite_o, r0Write_o, RA1_o, WBData_o, R0D_o}), 64'd0);
        check("rst_err_stall", 64'({err_o, stall}), 64'd0);
        reset = 1'b0;

        push_wb(1, 0, 4'h3, 16'h1234, 16'h0005);
        issue(mk(1, 0, 0, 0, 0, 4'h3, 16'h1234, 16'h0000, 16'h0005), -1, 16'h0, 0, "alu_basic");
        push_wb(1, 1, 4'hF, 16'hFFFF, 16'hA5A5);
        issue(mk(1, 1, 0, 0, 1, 4'hF, 16'hFFFF, 16'h0101, 16'hA5A5), -1, 16'h0, 0, "alu_r0");

        push_req(0, 16'h0040, 16'h7777, 2);
        push_wb(1, 0, 4'h5, 16'hBEEF, 16'h0011);
        issue(mk(1, 0, 1, 0, 1, 4'h5, 16'h0040, 16'h7777, 16'h0011), 1, 16'hBEEF, 2, "load");

        push_req(1, 16'h0010, 16'h00AA, 1);
        issue(mk(0, 0, 0, 1, 0, 4'h6, 16'h0010, 16'h00AA, 16'h0022), 0, 16'h5A5A, 1, "store");

        push_req(0, 16'h0123, 16'h0000, 3);
        push_wb(1, 0, 4'h7, 16'h0123, 16'h0033);
        issue(mk(1, 0, 1, 0, 0, 4'h7, 16'h0123, 16'h0000, 16'h0033), 2, 16'hDEAD, 3, "load_alu_src");

        push_req(1, 16'h0200, 16'h5555, 1);
        issue(mk(0, 0, 1, 1, 1, 4'h2, 16'h0200, 16'h5555, 16'h0000), 0, 16'h9999, 1, "rd_wr_both");

        push_req(0, 16'h0050, 16'h0000, 1);
        push_wb(1, 0, 4'h4, 16'h1111, 16'h0044);
        push_req(1, 16'h0060, 16'h2222, 1);
        push_wb(1, 0, 4'h9, 16'h0909, 16'h0000);
        issue(mk(1, 0, 1, 0, 1, 4'h4, 16'h0050, 16'h0000, 16'h0044), 0, 16'h1111, 1, "b2b_load");
        issue(mk(0, 0, 0, 1, 0, 4'h0, 16'h0060, 16'h2222, 16'h0000), 0, 16'h0000, 1, "b2b_store");
        issue(mk(1, 0, 0, 0, 0, 4'h9, 16'h0909, 16'h0000, 16'h0000), -1, 16'h0, 0, "b2b_alu");

        push_req(0, 16'h0300, 16'h0000, 4);
        push_wb(1, 0, 4'h6, 16'hCAFE, 16'h0055);
        issue(mk(1, 0, 1, 0, 1, 4'h6, 16'h0300, 16'h0000, 16'h0055), 3, 16'hCAFE, 4, "late_ack");
        check("late_ack_no_err", 64'(err_o), 64'd0);

        push_req(0, 16'h0400, 16'h0044, 4);
        issue(mk(1, 0, 1, 0, 1, 4'h8, 16'h0400, 16'h0044, 16'h3333), -1, 16'h0, 4, "timeout");
        check("timeout_err", 64'(err_o), 64'd1);
        check("timeout_bubble", 64'({regWrite_o, r0Write_o, RA1_o, WBData_o, R0D_o}), 64'd0);

        mem_ack   = 1'b1;
        mem_rdata = 16'hBAD0;
        #1;
        check("stray_ack_stall", 64'(stall), 64'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_no_req", 64'(mem_req), 64'd0);
        check("err_sticky", 64'(err_o), 64'd1);

        push_wb(1, 0, 4'h1, 16'h0A0A, 16'h0000);
        issue(mk(1, 0, 0, 0, 0, 4'h1, 16'h0A0A, 16'h0000, 16'h0000), -1, 16'h0, 0, "alu_after_err");

        push_req(0, 16'h0500, 16'h0066, 2);
        drive(mk(1, 0, 1, 0, 1, 4'hB, 16'h0500, 16'h0066, 16'h0777));
        repeat (2) @(negedge clk);
        check("busy_before_reset", 64'(mem_req), 64'd1);
        reset = 1'b1;
        drive(nop);
        @(negedge clk);
        check("rst_busy_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
        check("rst_busy_wb", 64'({regWrite_o, r0Write_o, RA1_o, WBData_o, R0D_o}), 64'd0);
        check("rst_busy_err", 64'(err_o), 64'd0);
        reset = 1'b0;

        push_wb(1, 1, 4'hC, 16'h4321, 16'h0F0F);
        issue(mk(1, 1, 0, 0, 0, 4'hC, 16'h4321, 16'h0000, 16'h0F0F), -1, 16'h0, 0, "alu_after_rst");

        repeat (3) @(negedge clk);
        check("wb_q_drained", 64'(wb_q.size()), 64'd0);
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
